// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : priority_encoder
//  Description : Combinational priority encoder. Reports whether any input
//                bit is set and the index of the highest-priority set bit.
//                LSB_HIGH_PRIORITY=1 makes bit 0 win, otherwise the MSB wins.
//  Ports       : i_unencoded  [WIDTH]          input bit vector
//                o_valid      [1]              any bit set
//                o_encoded    [$clog2(WIDTH)]  index of winning bit (0 if none)
//  Revision    : 1.0  initial release
// ============================================================================
module priority_encoder #(
    parameter int WIDTH             = 4,
    parameter int LSB_HIGH_PRIORITY = 0
) (
    input  logic [WIDTH-1:0]         i_unencoded,
    output logic                     o_valid,
    output logic [$clog2(WIDTH)-1:0] o_encoded
);

    localparam int c_idx_w = $clog2(WIDTH);

    always_comb begin
        o_valid   = 1'b0;
        o_encoded = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (LSB_HIGH_PRIORITY != 0) begin
                // first set bit from the bottom wins
                if (i_unencoded[i] && !o_valid) begin
                    o_valid   = 1'b1;
                    o_encoded = c_idx_w'(i);
                end
            end else begin
                // scanning upward, the last set bit (highest index) wins
                if (i_unencoded[i]) begin
                    o_valid   = 1'b1;
                    o_encoded = c_idx_w'(i);
                end
            end
        end
    end

endmodule

// ============================================================================
//  Module      : wb_rr_arbiter
//  Description : Registered N-port Wishbone bus arbiter. Fixed-priority or
//                round-robin selection, optional grant hold until release
//                (on acknowledge or on request drop).
//  Ports       : clk            [1]              clock, rising edge
//                rst            [1]              async active-high reset
//                request        [PORTS]          per-port request level
//                acknowledge    [PORTS]          per-port release pulse
//                grant          [PORTS]          registered one-hot grant
//                grant_valid    [1]              registered, grant nonzero
//                grant_encoded  [$clog2(PORTS)]  registered grant index
//  Revision    : 1.0  initial release
// ============================================================================
module wb_rr_arbiter #(
    parameter int PORTS                = 4,
    parameter int ARB_TYPE_ROUND_ROBIN = 1,
    parameter int ARB_BLOCK            = 1,
    parameter int ARB_BLOCK_ACK        = 1,
    parameter int LSB_HIGH_PRIORITY    = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PORTS-1:0]         request,
    input  logic [PORTS-1:0]         acknowledge,
    output logic [PORTS-1:0]         grant,
    output logic                     grant_valid,
    output logic [$clog2(PORTS)-1:0] grant_encoded
);

    localparam int c_idx_w = $clog2(PORTS);

    logic [PORTS-1:0]   r_grant;
    logic               r_grant_valid;
    logic [c_idx_w-1:0] r_grant_encoded;
    logic [PORTS-1:0]   r_mask;

    logic [PORTS-1:0]   w_masked_req;
    logic               w_raw_valid;
    logic               w_masked_valid;
    logic [c_idx_w-1:0] w_raw_idx;
    logic [c_idx_w-1:0] w_masked_idx;
    logic [c_idx_w-1:0] w_win;
    logic               w_release;
    logic               w_arbitrate;
    logic               w_update_mask;
    logic               w_valid_next;
    logic [c_idx_w-1:0] w_enc_next;
    logic [PORTS-1:0]   w_grant_next;
    logic [PORTS-1:0]   w_mask_next;

    assign w_masked_req = request & r_mask;

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
    ) u_enc_raw (
        .i_unencoded (request),
        .o_valid     (w_raw_valid),
        .o_encoded   (w_raw_idx)
    );

    priority_encoder #(
        .WIDTH             (PORTS),
        .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
    ) u_enc_masked (
        .i_unencoded (w_masked_req),
        .o_valid     (w_masked_valid),
        .o_encoded   (w_masked_idx)
    );

    // Mask for the next round: only ports strictly "after" the winner in
    // priority order stay eligible. An empty mask makes the next arbitration
    // fall back to the raw requests, which gives the wrap-around.
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_mask_bits
        if (LSB_HIGH_PRIORITY != 0) begin : g_lsb
            assign w_mask_next[gi] = (c_idx_w'(gi) > w_win);
        end else begin : g_msb
            assign w_mask_next[gi] = (c_idx_w'(gi) < w_win);
        end
    end

    // Only the granted port's bit is ever looked at; acknowledges on other
    // ports, or while idle, have no effect.
    assign w_release = (ARB_BLOCK_ACK != 0) ? acknowledge[r_grant_encoded]
                                            : ~request[r_grant_encoded];

    always_comb begin
        w_win         = w_raw_idx;
        w_arbitrate   = 1'b1;
        w_update_mask = 1'b0;
        w_valid_next  = r_grant_valid;
        w_enc_next    = r_grant_encoded;

        if ((ARB_TYPE_ROUND_ROBIN != 0) && w_masked_valid) begin
            w_win = w_masked_idx;
        end

        if (ARB_BLOCK != 0) begin
            w_arbitrate = !r_grant_valid || w_release;
        end

        if (w_arbitrate) begin
            w_valid_next = w_raw_valid;
            w_enc_next   = w_raw_valid ? w_win : '0;
            if (ARB_BLOCK != 0) begin
                w_update_mask = w_raw_valid;
            end else begin
                // re-arbitrating every cycle: rotate only on a real change
                w_update_mask = w_raw_valid &&
                                (!r_grant_valid || (w_win != r_grant_encoded));
            end
        end

        w_grant_next = w_valid_next ? (PORTS'(1) << w_enc_next) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant         <= '0;
            r_grant_valid   <= 1'b0;
            r_grant_encoded <= '0;
            r_mask          <= '1;
        end else begin
            r_grant         <= w_grant_next;
            r_grant_valid   <= w_valid_next;
            r_grant_encoded <= w_enc_next;
            if (w_update_mask) begin
                r_mask <= w_mask_next;
            end
        end
    end

    assign grant         = r_grant;
    assign grant_valid   = r_grant_valid;
    assign grant_encoded = r_grant_encoded;

endmodule
`default_nettype wire
